// File: rtl/riscv_instr_loader.sv
// Instruction-memory loader: turns a 32-bit word stream (address header, byte count,
// packed data) into byte-wide writes on the picorv32 instruction config port.
module riscv_instr_loader #(
    parameter int ADDR_BITS = 24,
    parameter int LEN_BITS  = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          din,
    input  logic                 val_in,
    output logic                 ready_upward,
    output logic [ADDR_BITS-1:0] instr_config_addr,
    output logic [7:0]           instr_config_din,
    output logic                 instr_config_wr_en,
    output logic                 busy,
    output logic                 done
);

    // state   | meaning
    // S_ADDR  | waiting for header word (start address)
    // S_LEN   | waiting for byte-count word
    // S_FETCH | waiting for next packed data word
    // S_EMIT  | writing one byte per cycle from the latched word
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_ADDR  = 3'd0,
        S_LEN   = 3'd1,
        S_FETCH = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_BITS-1:0] r_cur_addr;
    logic [LEN_BITS-1:0]  r_remaining;
    logic [31:0]          r_shreg;
    logic [1:0]           r_idx;
    logic                 w_xfer;

    // Gating with resetn keeps ready low while reset is held even though S_ADDR accepts.
    assign ready_upward       = resetn && ((r_state == S_ADDR) || (r_state == S_LEN) ||
                                           (r_state == S_FETCH));
    assign w_xfer             = val_in && ready_upward;
    assign instr_config_wr_en = (r_state == S_EMIT);
    assign instr_config_addr  = r_cur_addr;
    assign instr_config_din   = r_shreg[{r_idx, 3'b000} +: 8];
    assign busy               = (r_state != S_ADDR);
    assign done               = (r_state == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ADDR: begin
                if (w_xfer) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) w_next = (din[LEN_BITS-1:0] == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (w_xfer) w_next = S_EMIT;
            end
            S_EMIT: begin
                if (r_remaining == LEN_BITS'(1)) w_next = S_DONE;
                else if (r_idx == 2'd3)          w_next = S_FETCH;
            end
            S_DONE:  w_next = S_ADDR;
            default: w_next = S_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_shreg     <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_xfer) r_cur_addr <= din[ADDR_BITS-1:0];
                end
                S_LEN: begin
                    if (w_xfer) r_remaining <= din[LEN_BITS-1:0];
                end
                S_FETCH: begin
                    if (w_xfer) begin
                        r_shreg <= din;
                        r_idx   <= 2'd0;
                    end
                end
                S_EMIT: begin
                    // Address wraps naturally at 2^ADDR_BITS; the count is independent of it.
                    r_cur_addr  <= r_cur_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_idx       <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Scoreboard bench for riscv_instr_loader: a driver pushes the bytes each load should
// produce, a negedge monitor pops and compares them as the DUT writes.
module tb_riscv_instr_loader;

    logic        clk;
    logic        resetn;
    logic [31:0] din;
    logic        val_in;
    logic        ready_upward;
    logic [23:0] instr_config_addr;
    logic [7:0]  instr_config_din;
    logic        instr_config_wr_en;
    logic        busy;
    logic        done;

    riscv_instr_loader #(.ADDR_BITS(24), .LEN_BITS(24)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .din               (din),
        .val_in            (val_in),
        .ready_upward      (ready_upward),
        .instr_config_addr (instr_config_addr),
        .instr_config_din  (instr_config_din),
        .instr_config_wr_en(instr_config_wr_en),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_wr[$];
    bit          exp_done[$];   // element = whether a write precedes the done pulse
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] wbuf[0:3];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    bit prev_wr = 0;
    bit after_done = 0;
    int run = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_wr    = 0;
            after_done = 0;
            run        = 0;
        end else begin
            if (after_done) begin
                check("ready_after_done", {63'd0, ready_upward}, 64'd1);
                check("idle_after_done", {63'd0, busy}, 64'd0);
                after_done = 0;
            end
            if (instr_config_wr_en) begin
                run++;
                check("busy_in_write", {63'd0, busy}, 64'd1);
                check("ready_in_write", {63'd0, ready_upward}, 64'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {40'd0, instr_config_addr}, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_addr_data", {32'd0, instr_config_addr, instr_config_din},
                          {32'd0, e.a, e.d});
                end
            end else begin
                if (run > 0) check("burst_len_le4", {63'd0, run <= 4}, 64'd1);
                run = 0;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    bit pw;
                    pw = exp_done.pop_front();
                    check("done_after_last_write", {63'd0, prev_wr}, {63'd0, pw});
                end
                after_done = 1;
            end
            prev_wr = instr_config_wr_en;
        end
    end

    // Driver: called just after a negedge; returns at the negedge following the transfer.
    task automatic send_word(input logic [31:0] w);
        int cnt;
        cnt    = 0;
        din    = w;
        val_in = 1'b1;
        while (!ready_upward && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        val_in = 1'b0;
        din    = $urandom;
    endtask

    task automatic idle(input int n);
        val_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reference: byte i of the load lands at (start+i) mod 2^24, taken LSB-first from word i/4.
    task automatic push_expect(input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            logic [31:0] w;
            w   = wbuf[i / 4];
            e.a = a + 24'(i);
            e.d = 8'(w >> (8 * (i % 4)));
            exp_wr.push_back(e);
        end
    endtask

    task automatic load(input logic [23:0] a, input int n, input bit gaps);
        int nw;
        nw = (n + 3) / 4;
        push_expect(a, n);
        exp_done.push_back(n > 0);
        send_word({8'($urandom), a});
        if (gaps) idle($urandom_range(0, 2));
        send_word({8'($urandom), 24'(n)});
        for (int k = 0; k < nw; k++) begin
            if (gaps) idle($urandom_range(0, 3));
            send_word(wbuf[k]);
        end
    endtask

    initial begin
        resetn = 1'b0;
        val_in = 1'b0;
        din    = 32'h0;
        #1;
        check("rst_ready", {63'd0, ready_upward}, 64'd0);
        check("rst_outs", {39'd0, instr_config_wr_en, done, busy, instr_config_addr},
              64'd0);
        check("rst_dout", {56'd0, instr_config_din}, 64'd0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {63'd0, ready_upward}, 64'd1);
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        // Scenario 1: two full words
        wbuf[0] = 32'h44332211; wbuf[1] = 32'h88776655;
        load(24'h000100, 8, 0);
        idle(8);

        // Scenario 2: partial last word
        wbuf[0] = 32'hDDCCBBAA; wbuf[1] = 32'h123456EE;
        load(24'h000020, 5, 0);
        idle(8);

        // Scenario 3: zero length, back-to-back with a following load
        exp_done.push_back(0);
        send_word({8'h00, 24'h000040});
        send_word(32'h0);
        check("len0_done_pulse", {63'd0, done}, 64'd1);
        wbuf[0] = 32'h0A0B0C0D;
        load(24'h000050, 2, 0);
        idle(8);

        // Scenario 4: address wrap
        wbuf[0] = 32'h04030201;
        load(24'hFFFFFE, 4, 0);
        idle(8);

        // Scenario 5: input stall between data words
        wbuf[0] = 32'h44332211; wbuf[1] = 32'h88776655;
        push_expect(24'h000100, 8);
        exp_done.push_back(1);
        send_word(32'h000100);
        send_word(32'd8);
        send_word(wbuf[0]);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", {63'd0, ready_upward}, 64'd1);
            check("stall_no_write", {63'd0, instr_config_wr_en}, 64'd0);
            check("stall_busy", {63'd0, busy}, 64'd1);
            if (i < 2) @(negedge clk);
        end
        send_word(wbuf[1]);
        idle(10);

        // Scenario 6: reset on the second write of a burst
        wbuf[0] = 32'hA1A2A3A4;
        push_expect(24'h000300, 2);
        send_word(32'h000300);
        send_word(32'd8);
        send_word(wbuf[0]);
        @(negedge clk);
        check("second_write_seen", {63'd0, instr_config_wr_en}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("midrst_wr_en", {63'd0, instr_config_wr_en}, 64'd0);
            check("midrst_busy", {63'd0, busy}, 64'd0);
            check("midrst_ready", {63'd0, ready_upward}, 64'd0);
            @(negedge clk);
        end
        #2 resetn = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", {63'd0, ready_upward}, 64'd1);
        idle(10);

        // Randomized loads against the reference
        for (int t = 0; t < 25; t++) begin
            logic [23:0] a;
            int n;
            a = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 + 24'($urandom_range(0, 15))
                                            : 24'($urandom);
            n = $urandom_range(0, 14);
            for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
            load(a, n, 1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 6));
        end

        for (int i = 0; i < 300 && (exp_wr.size() != 0 || exp_done.size() != 0); i++)
            @(negedge clk);
        idle(4);
        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        check("pending_done", 64'(exp_done.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
